// File: rtl/mat_job_sched.sv
// mat_job_sched: shares one matrix-multiply engine between two requesters.
// Arbitration is round-robin. The winner's tag is latched, and the engine gets
// a one-cycle start pulse. The tagged completion is returned to the owner.
// Optional build macro MAT_SCHED_TIMEOUT_EN adds a RUN-state watchdog.
// The watchdog aborts the job after TIMEOUT cycles.
module mat_job_sched #(
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [TAG_W-1:0] tag0,
    input  logic [TAG_W-1:0] tag1,
    input  logic             eng_ready,
    input  logic             eng_done,
    output logic [1:0]       gnt,
    output logic             eng_start,
    output logic [1:0]       done,
    output logic [TAG_W-1:0] done_tag,
    output logic             abort,
    output logic             owner,
    output logic             busy,
    output logic [7:0]       job_cnt
);

    typedef enum logic [1:0] {IDLE, GRANT, RUN, RELEASE} state_t;

    state_t           state_q, state_d;
    logic             prio_q;
    logic             owner_q;
    logic [TAG_W-1:0] tag_q;
    logic             abort_q;
    logic [7:0]       job_cnt_q;
    logic             win;
    logic             take;
    logic             finish;
    logic             timeout_hit;

    // The watchdog limit must fit the 8-bit RUN counter.
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mat_job_sched: TIMEOUT out of range 1..255");
    end

    // Select the winner: a sole requester wins, and a tie goes to prio.
    always_comb begin
        win  = (req == 2'b11) ? prio_q : req[1];
        take = (state_q == IDLE) && (req != 2'b00) && eng_ready;
    end

`ifdef MAT_SCHED_TIMEOUT_EN
    logic [7:0] wd_cnt_q;

    // RUN-cycle counter: cleared during GRANT so it starts at 0 on entering RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  wd_cnt_q <= 8'd0;
        else if (state_q == GRANT) wd_cnt_q <= 8'd0;
        else if (state_q == RUN)   wd_cnt_q <= wd_cnt_q + 8'd1;
    end

    assign timeout_hit = (state_q == RUN) && (wd_cnt_q == 8'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    assign finish = (state_q == RUN) && (eng_done || timeout_hit);

    // Next-state logic: eng_done is only observed in RUN.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (take) state_d = GRANT;
            GRANT:   state_d = RUN;
            RUN:     if (finish) state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered state, job context, and completion counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            owner_q   <= 1'b0;
            tag_q     <= '0;
            abort_q   <= 1'b0;
            job_cnt_q <= 8'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every register sees pre-edge values.
            state_q <= state_d;
            if (take) begin
                owner_q <= win;
                tag_q   <= win ? tag1 : tag0;
                prio_q  <= ~win;
            end
            if (finish) begin
                // A coincident eng_done makes an expiring job a normal completion.
                abort_q   <= timeout_hit & ~eng_done;
                job_cnt_q <= job_cnt_q + 8'd1;
            end
        end
    end

    // Outputs are decoded only from registered state.
    always_comb begin
        gnt       = 2'b00;
        done      = 2'b00;
        done_tag  = '0;
        abort     = 1'b0;
        eng_start = (state_q == GRANT);
        if (state_q == GRANT) gnt = owner_q ? 2'b10 : 2'b01;
        if (state_q == RELEASE) begin
            done     = owner_q ? 2'b10 : 2'b01;
            done_tag = tag_q;
            abort    = abort_q;
        end
        owner   = owner_q;
        busy    = (state_q != IDLE);
        job_cnt = job_cnt_q;
    end

endmodule
